// File: rtl/simd_add_issue.sv
// Issue stage for a downstream SIMD adder: buffers lane-mode requests in a 2-entry FIFO and
// drives operands plus one-hot lane selects from the head entry.
module simd_add_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_mode,
    input  logic        in_sub,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic        H,
    output logic        O,
    output logic        Q,
    output logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam logic [1:0] ModeQuad = 2'b00;
    localparam logic [1:0] ModeOct  = 2'b01;
    localparam logic [1:0] ModeHalf = 2'b10;
    localparam logic [1:0] ModeBad  = 2'b11;

    logic [1:0]  mode_q [2];
    logic        sub_q  [2];
    logic [15:0] a_q    [2];
    logic [15:0] b_q    [2];

    logic        rd_ptr_q, wr_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        err_q;
    logic [7:0]  err_cnt_q;

    logic        accept, push, pop, bad;
    logic [1:0]  head_mode;

    always_comb begin
        in_ready  = (count_q < 2'd2);
        out_valid = (count_q != 2'd0);
        accept    = in_valid & in_ready;
        push      = accept & (in_mode != ModeBad);
        bad       = accept & (in_mode == ModeBad);
        pop       = out_valid & out_ready;
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
            err_q   <= bad;
            if (bad && (err_cnt_q != 8'hff)) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    // Storage needs no reset: every output that reads it is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mode_q[wr_ptr_q] <= in_mode;
            sub_q[wr_ptr_q]  <= in_sub;
            a_q[wr_ptr_q]    <= in_a;
            b_q[wr_ptr_q]    <= in_b;
        end
    end

    always_comb begin
        head_mode = mode_q[rd_ptr_q];
        A         = out_valid ? a_q[rd_ptr_q] : 16'h0000;
        B         = out_valid ? b_q[rd_ptr_q] : 16'h0000;
        Q         = out_valid & (head_mode == ModeQuad);
        O         = out_valid & (head_mode == ModeOct);
        H         = out_valid & (head_mode == ModeHalf);
        sub       = out_valid & sub_q[rd_ptr_q];
        err       = err_q;
        err_cnt   = err_cnt_q;
    end

endmodule

// File: tb/tb_simd_add_issue.sv
// Self-checking bench for simd_add_issue: directed scenarios plus randomized traffic checked
// against a queue-based model of the issue FIFO.
module tb_simd_add_issue;

    typedef struct packed {
        logic [1:0]  mode;
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_sub, out_valid, out_ready;
    logic [1:0]  in_mode;
    logic [15:0] in_a, in_b, A, B;
    logic        H, O, Q, sub, err;
    logic [7:0]  err_cnt;
    logic [46:0] dut_vec;

    ent_t        mq[$];
    logic        exp_err;
    int          exp_cnt;
    int          passed, total;

    always #5 clk = ~clk;

    simd_add_issue dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_sub   (in_sub),
        .in_a     (in_a),
        .in_b     (in_b),
        .A        (A),
        .B        (B),
        .H        (H),
        .O        (O),
        .Q        (Q),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    assign dut_vec = {in_ready, out_valid, A, B, H, O, Q, sub, err, err_cnt};

    // Expected outputs from the model queue: head entry or all zeros when empty.
    function automatic logic [46:0] model_vec();
        ent_t h;
        logic v;
        logic [7:0] c;
        v = (mq.size() > 0);
        if (v) h = mq[0];
        else   h = '0;
        c = exp_cnt[7:0];
        return {(mq.size() < 2), v, h.a, h.b, v && h.mode == 2'd2, v && h.mode == 2'd1,
                v && h.mode == 2'd0, v && h.sub, exp_err, c};
    endfunction

    // Behaviour of the downstream adder, lane by lane.
    function automatic logic [15:0] lane_add(input logic [15:0] a, input logic [15:0] b,
                                             input logic h, input logic o, input logic q,
                                             input logic s);
        logic [15:0] r;
        r = 16'h0;
        if (h) r = s ? a - b : a + b;
        if (o) for (int i = 0; i < 2; i++)
            r[i*8 +: 8] = s ? a[i*8 +: 8] - b[i*8 +: 8] : a[i*8 +: 8] + b[i*8 +: 8];
        if (q) for (int i = 0; i < 4; i++)
            r[i*4 +: 4] = s ? a[i*4 +: 4] - b[i*4 +: 4] : a[i*4 +: 4] + b[i*4 +: 4];
        return r;
    endfunction

    // Advance one clock; inputs are applied beforehand in the negedge phase.
    task automatic tick();
        logic acc, pp;
        ent_t e;
        acc = in_valid && (mq.size() < 2);
        pp  = out_ready && (mq.size() > 0);
        e.mode = in_mode; e.sub = in_sub; e.a = in_a; e.b = in_b;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            exp_err = 1'b0;
            exp_cnt = 0;
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc && in_mode != 2'b11) mq.push_back(e);
            exp_err = acc && (in_mode == 2'b11);
            if (exp_err && exp_cnt < 255) exp_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic set_req(input logic [1:0] m, input logic s, input logic [15:0] a,
                           input logic [15:0] b);
        in_valid = 1'b1; in_mode = m; in_sub = s; in_a = a; in_b = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(2'b00, 1'b1, 16'($urandom), 16'($urandom));
        out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        total++;
        if (dut_vec !== model_vec()) $display("FAIL reset_state: got %h want %h", dut_vec, model_vec());
        else passed++;
        total++;
        if ({in_ready, out_valid, A, B, H, O, Q, sub} !== {2'b10, 32'h0, 4'h0})
            $display("FAIL reset_idle: got rdy=%b vld=%b A=%h B=%h", in_ready, out_valid, A, B);
        else passed++;
    endtask

    task automatic test_quad_add();
        out_ready = 1'b1;
        set_req(2'b00, 1'b0, 16'h1234, 16'h1111);
        tick();
        in_valid = 1'b0;
        total++;
        if (dut_vec !== model_vec()) $display("FAIL quad_issue: got %h want %h", dut_vec, model_vec());
        else passed++;
        total++;
        if (lane_add(A, B, H, O, Q, sub) !== 16'h2345 || {out_valid, Q, H, O, sub} !== 5'b11000)
            $display("FAIL quad_sum: got %h want 2345", lane_add(A, B, H, O, Q, sub));
        else passed++;
        tick();
        total++;
        if (dut_vec !== model_vec()) $display("FAIL quad_drain: got %h want %h", dut_vec, model_vec());
        else passed++;
    endtask

    task automatic test_half_sub();
        out_ready = 1'b1;
        set_req(2'b10, 1'b1, 16'h0005, 16'h0007);
        tick();
        in_valid = 1'b0;
        total++;
        if (lane_add(A, B, H, O, Q, sub) !== 16'hfffe || {H, O, Q, sub} !== 4'b1001)
            $display("FAIL half_sub: got %h sel=%b want fffe", lane_add(A, B, H, O, Q, sub),
                     {H, O, Q, sub});
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] ea[3];
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ea[i] = 16'($urandom);
            set_req(2'($urandom_range(0, 2)), 1'($urandom), ea[i], 16'($urandom));
            total++;
            if (in_ready !== (i < 2)) $display("FAIL b2b_ready%0d: got %b want %b", i, in_ready, i < 2);
            else passed++;
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (A !== ea[0] || dut_vec !== model_vec())
            $display("FAIL b2b_hold: got A=%h want %h", A, ea[0]);
        else passed++;
        out_ready = 1'b1;
        tick();
        total++;
        if (A !== ea[1] || dut_vec !== model_vec())
            $display("FAIL b2b_second: got A=%h want %h", A, ea[1]);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL b2b_empty: got out_valid=%b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        set_req(2'b11, 1'b0, 16'h1, 16'h2);
        tick();
        in_valid = 1'b0;
        total++;
        if ({err, out_valid, err_cnt} !== {2'b10, 8'd1})
            $display("FAIL illegal_pulse: got err=%b vld=%b cnt=%0d want 1 0 1", err, out_valid, err_cnt);
        else passed++;
        tick();
        total++;
        if (err !== 1'b0) $display("FAIL illegal_once: got err=%b want 0", err);
        else passed++;
        set_req(2'b11, 1'b1, 16'h0, 16'h0);
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        total++;
        if (err_cnt !== 8'd255 || dut_vec !== model_vec())
            $display("FAIL illegal_saturate: got cnt=%0d want 255", err_cnt);
        else passed++;
        tick();
    endtask

    task automatic test_push_pop();
        logic [15:0] a2;
        out_ready = 1'b0;
        set_req(2'b01, 1'b0, 16'haaaa, 16'h5555);
        tick();
        a2 = 16'($urandom);
        set_req(2'b00, 1'b1, a2, 16'h0f0f);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        total++;
        if (A !== a2 || in_ready !== 1'b1 || dut_vec !== model_vec())
            $display("FAIL push_pop: got A=%h rdy=%b want %h 1", A, in_ready, a2);
        else passed++;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_req(2'($urandom_range(0, 2)), 1'($urandom), 16'($urandom), 16'($urandom));
            tick();
        end
        set_req(2'b10, 1'b0, 16'hdead, 16'hbeef);
        out_ready = 1'b1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL full_pop_ready: got %b want 0", in_ready);
        else passed++;
        tick();
        in_valid = 1'b0;
        total++;
        if (dut_vec !== model_vec()) $display("FAIL full_pop_state: got %h want %h", dut_vec, model_vec());
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_req(2'($urandom_range(0, 2)), 1'b1, 16'($urandom) | 16'h1, 16'($urandom) | 16'h1);
            tick();
        end
        set_req(2'b11, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        total++;
        if ({in_ready, out_valid, err, err_cnt, A, B, H, O, Q, sub} !== {3'b100, 8'd0, 36'h0})
            $display("FAIL reset_mid: got rdy=%b vld=%b err=%b cnt=%0d A=%h B=%h",
                     in_ready, out_valid, err, err_cnt, A, B);
        else passed++;
        tick();
        total++;
        if (dut_vec !== model_vec()) $display("FAIL reset_mid_after: got %h want %h", dut_vec, model_vec());
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            in_valid  = 1'($urandom);
            in_mode   = 2'($urandom);
            in_sub    = 1'($urandom);
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            out_ready = 1'($urandom);
            tick();
            total++;
            if (dut_vec !== model_vec() || $countones({H, O, Q}) != (out_valid ? 1 : 0))
                $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec, model_vec());
            else passed++;
        end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        passed = 0; total = 0;
        exp_err = 1'b0; exp_cnt = 0;
        rst = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_sub = 1'b0;
        in_a = 16'h0; in_b = 16'h0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_quad_add();
        test_half_sub();
        test_back_to_back();
        test_illegal();
        test_push_pop();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/simd_add_issue.md
SIMD_ADD_ISSUE -- requirements
Module: simd_add_issue

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1: upstream request valid.
REQ-004 SHALL have port in_ready, output, 1: block can accept a request this cycle.
REQ-005 SHALL have port in_mode, input, 2: lane mode; 00 = four 4-bit lanes, 01 = two 8-bit lanes, 10 = one 16-bit lane, 11 = illegal.
REQ-006 SHALL have port in_sub, input, 1: 1 = subtract (A-B per lane), 0 = add.
REQ-007 SHALL have port in_a, input, 16: operand A.
REQ-008 SHALL have port in_b, input, 16: operand B.
REQ-009 SHALL have port A, output, 16: operand A to the downstream SIMD adder.
REQ-010 SHALL have port B, output, 16: operand B to the downstream SIMD adder.
REQ-011 SHALL have port H, output, 1: 16-bit lane select to the adder.
REQ-012 SHALL have port O, output, 1: 8-bit lane select to the adder.
REQ-013 SHALL have port Q, output, 1: 4-bit lane select to the adder.
REQ-014 SHALL have port sub, output, 1: subtract select to the adder.
REQ-015 SHALL have port out_valid, output, 1: A/B/H/O/Q/sub hold a valid operation.
REQ-016 SHALL have port out_ready, input, 1: consumer has taken the adder result this cycle.
REQ-017 SHALL have port err, output, 1: one-cycle pulse on an illegal-mode request.
REQ-018 SHALL have port err_cnt, output, 8: saturating count of illegal requests.

Function
REQ-019 SHALL hold requests in a 2-entry FIFO (entry = mode, sub, a, b), count 0..2.
REQ-020 SHALL drive in_ready = (count < 2), from registered state only.
REQ-021 SHALL accept a request when in_valid & in_ready.
REQ-022 SHALL pop the head when out_valid & out_ready.
REQ-023 SHALL drive out_valid = (count > 0).
REQ-024 SHALL enqueue accepted legal requests (mode 00/01/10) at the tail.
REQ-025 SHALL complete the handshake for an accepted illegal request (mode 11) but not enqueue it; pulse err the next cycle; increment err_cnt, saturating at 255.
REQ-026 SHALL drive A/B from the head entry while out_valid is 1, and 0 otherwise.
REQ-027 SHALL decode head mode 00 -> Q=1, H=O=0; 01 -> O=1, H=Q=0; 10 -> H=1, O=Q=0.
REQ-028 SHALL drive sub from the head entry.
REQ-029 SHALL, when out_valid is 0, drive H=O=Q=sub=0.
REQ-030 SHALL keep exactly one of H/O/Q high whenever out_valid is 1.
REQ-031 SHALL have latency 1 cycle: a request accepted at edge N into an empty FIFO appears on outputs after edge N.
REQ-032 SHALL support push and pop in the same cycle; count is then unchanged and FIFO order is preserved.
REQ-033 SHALL, when count = 2 and a pop occurs, keep in_ready low in that cycle; no same-cycle refill when full.
REQ-034 SHALL keep head outputs stable while out_valid & ~out_ready.
REQ-035 SHALL ignore in_* while in_valid is 0 or in_ready is 0.

Reset
REQ-036 SHALL, while rst is 1 at a clock edge, set count=0, err=0, err_cnt=0 and clear FIFO pointers.
REQ-037 SHALL therefore, after reset, give in_ready=1, out_valid=0, A=B=0 and H=O=Q=sub=0.
REQ-038 SHALL, on reset mid-operation, discard queued entries with no output or err pulse for them.
REQ-039 SHALL give rst priority over simultaneous push/pop.

Verification
REQ-040 Scenario 1: in_mode=00, in_sub=0, in_a=16'h1234, in_b=16'h1111, out_ready=1 -> next cycle out_valid=1, A=16'h1234, B=16'h1111, Q=1, H=O=sub=0, with the adder producing 16'h2345.
REQ-041 Scenario 2: in_mode=10, in_sub=1, A=16'h0005, B=16'h0007 -> H=1, sub=1, with the adder producing 16'hFFFE.
REQ-042 Scenario 3: out_ready=0 with three back-to-back requests -> first two accepted, in_ready=0 on the third; outputs hold entry 1; after out_ready=1, entries 1 then 2 are issued in order.
REQ-043 Scenario 4: in_mode=11 -> handshake completes, out_valid stays 0, err pulses once, err_cnt=1; after 300 illegal requests err_cnt=255.
REQ-044 Scenario 5: count=1 with push and pop in the same cycle -> count stays 1 and the new entry becomes head.
REQ-045 Scenario 6: rst=1 asserted with count=2 -> next cycle out_valid=0, in_ready=1, err_cnt=0 and all adder inputs 0.
